cmd_master_queued: RTL and testbench

Parametrised successor to the SD host command master. Accepts commands from the host register file into a FIFO, then issues them one at a time to the command physical layer with a REQ/ACK four-phase handshake. For each command it collects a short (38-bit) or long (136-bit) response, checks the echoed index, enforces a per-command timeout, and optionally retries timed-out commands. It sits between the host register block and the CMD physical layer, on the CLK_host domain.

---
 rtl/cmd_master_queued.sv | 204 ++++++++++++++++++++
 tb/tb_cmd_master_queued.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_master_queued.sv
// ----------------------------------------------------------------------------
// cmd_master_queued : queued SD host command master, REQ/ACK to the CMD PHY.
// Optional retry-on-timeout when CMD_MASTER_RETRY_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cmd_master_queued #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int TO_W      = 16
) (
  input  logic            CLK_host,
  input  logic            reset,
  input  logic            new_cmd,
  input  logic [5:0]      cmd_index,
  input  logic [31:0]     cmd_arg,
  input  logic            resp_long,
  input  logic [TO_W-1:0] timeout_value,
  input  logic            cmd_error,
  input  logic            ACK_in,
  input  logic            REQ_in,
  input  logic [135:0]    cmd_response,
  output logic [37:0]     cmd_out,
  output logic            REQ_out,
  output logic            ACK_out,
  output logic [5:0]      response_index,
  output logic [31:0]     response_arg,
  output logic [127:0]    response_long,
  output logic            cmd_busy,
  output logic            queue_full,
  output logic            cmd_complete,
  output logic            cmd_index_error,
  output logic            timeout_error
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_RESP = 3'd2,
    RESP_ACK  = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state;

  logic [5:0]  fifo_index [DEPTH];
  logic [31:0] fifo_arg   [DEPTH];
  logic        fifo_long  [DEPTH];

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          fifo_empty, fifo_full, push, pop;

  logic            inflight_long;
  logic [TO_W-1:0] to_cnt, to_next;
  logic            timeout_hit, retry_allowed;
  logic            unused_resp_hi;

  assign wr_idx     = wr_ptr[AW-1:0];
  assign rd_idx     = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // An abort discards a same-cycle push as well as everything queued.
  assign push = new_cmd && !fifo_full && !cmd_error;
  assign pop  = (state == IDLE) && !fifo_empty && !cmd_error;

  assign queue_full = fifo_full;
  assign cmd_busy   = (state != IDLE) || !fifo_empty;

  assign to_next     = to_cnt + CNT_ONE;
  assign timeout_hit = (timeout_value != '0) && (to_next == timeout_value);

  assign unused_resp_hi = ^cmd_response[135:128];

`ifdef CMD_MASTER_RETRY_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
  logic [3:0] retry_cnt;
  assign retry_allowed = (retry_cnt < RETRY_LIMIT);
`else
  // Without retry support MAX_RETRY has no effect: never re-issue.
  assign retry_allowed = (MAX_RETRY < 0);
`endif

  always_ff @(posedge CLK_host) begin
    if (push) begin
      fifo_index[wr_idx] <= cmd_index;
      fifo_arg[wr_idx]   <= cmd_arg;
      fifo_long[wr_idx]  <= resp_long;
    end
  end

  always_ff @(posedge CLK_host or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cmd_out         <= '0;
      inflight_long   <= 1'b0;
      REQ_out         <= 1'b0;
      ACK_out         <= 1'b0;
      to_cnt          <= '0;
      response_index  <= '0;
      response_arg    <= '0;
      response_long   <= '0;
      cmd_complete    <= 1'b0;
      cmd_index_error <= 1'b0;
      timeout_error   <= 1'b0;
`ifdef CMD_MASTER_RETRY_EN
      retry_cnt       <= '0;
`endif
    end else begin
      cmd_complete    <= 1'b0;
      cmd_index_error <= 1'b0;
      timeout_error   <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;

      if (cmd_error) begin
        rd_ptr  <= wr_ptr;
        REQ_out <= 1'b0;
        ACK_out <= 1'b0;
        state   <= IDLE;
`ifdef CMD_MASTER_RETRY_EN
        retry_cnt <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              cmd_out       <= {fifo_index[rd_idx], fifo_arg[rd_idx]};
              inflight_long <= fifo_long[rd_idx];
              rd_ptr        <= rd_ptr + PTR_ONE;
              REQ_out       <= 1'b1;
              state         <= SEND;
`ifdef CMD_MASTER_RETRY_EN
              retry_cnt     <= '0;
`endif
            end
          end

          SEND: begin
            if (ACK_in) begin
              REQ_out <= 1'b0;
              to_cnt  <= '0;
              state   <= WAIT_RESP;
            end
          end

          WAIT_RESP: begin
            // A response sampled on the deadline edge still wins.
            if (REQ_in) begin
              response_arg <= cmd_response[31:0];
              if (inflight_long) begin
                response_index <= '0;
                response_long  <= cmd_response[127:0];
              end else begin
                response_index <= cmd_response[37:32];
                response_long  <= '0;
              end
              ACK_out <= 1'b1;
              state   <= RESP_ACK;
            end else if (timeout_hit) begin
              if (retry_allowed) begin
`ifdef CMD_MASTER_RETRY_EN
                retry_cnt <= retry_cnt + 4'd1;
`endif
                REQ_out <= 1'b1;
                state   <= SEND;
              end else begin
                timeout_error <= 1'b1;
`ifdef CMD_MASTER_RETRY_EN
                retry_cnt     <= '0;
`endif
                state         <= IDLE;
              end
            end else begin
              to_cnt <= to_next;
            end
          end

          RESP_ACK: begin
            if (!REQ_in) begin
              ACK_out         <= 1'b0;
              cmd_complete    <= 1'b1;
              cmd_index_error <= !inflight_long && (response_index != cmd_out[37:32]);
              state           <= DONE;
            end
          end

          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_master_queued.sv
// ----------------------------------------------------------------------------
// tb_cmd_master_queued : randomized host/PHY stimulus against a queue-based
// transaction model of cmd_master_queued.  Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cmd_master_queued;

  localparam int DEPTH     = 4;
  localparam int MAX_RETRY = 2;
  localparam int TO_W      = 16;
`ifdef CMD_MASTER_RETRY_EN
  localparam int ISSUES = MAX_RETRY + 1;
`else
  localparam int ISSUES = 1;
`endif

  logic            CLK_host = 1'b0;
  logic            reset    = 1'b1;
  logic            new_cmd  = 1'b0;
  logic [5:0]      cmd_index = '0;
  logic [31:0]     cmd_arg  = '0;
  logic            resp_long = 1'b0;
  logic [TO_W-1:0] timeout_value = '0;
  logic            cmd_error = 1'b0;
  logic            ACK_in   = 1'b0;
  logic            REQ_in   = 1'b0;
  logic [135:0]    cmd_response = '0;
  logic [37:0]     cmd_out;
  logic            REQ_out, ACK_out;
  logic [5:0]      response_index;
  logic [31:0]     response_arg;
  logic [127:0]    response_long;
  logic            cmd_busy, queue_full, cmd_complete, cmd_index_error, timeout_error;

  cmd_master_queued #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .TO_W(TO_W)) dut (
    .CLK_host(CLK_host), .reset(reset), .new_cmd(new_cmd), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_long(resp_long), .timeout_value(timeout_value),
    .cmd_error(cmd_error), .ACK_in(ACK_in), .REQ_in(REQ_in), .cmd_response(cmd_response),
    .cmd_out(cmd_out), .REQ_out(REQ_out), .ACK_out(ACK_out), .response_index(response_index),
    .response_arg(response_arg), .response_long(response_long), .cmd_busy(cmd_busy),
    .queue_full(queue_full), .cmd_complete(cmd_complete), .cmd_index_error(cmd_index_error),
    .timeout_error(timeout_error)
  );

  always #5 CLK_host = ~CLK_host;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        lng;
  } cmd_t;

  cmd_t        mq[$];
  logic [31:0] m_resp_arg = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_host);
    #1;
  endtask

  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                          input bit accept);
    cmd_t c;
    new_cmd = 1'b1; cmd_index = idx; cmd_arg = arg; resp_long = lng;
    tick();
    new_cmd = 1'b0;
    c.idx = idx; c.arg = arg; c.lng = lng;
    if (accept) mq.push_back(c);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (REQ_out !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("req_seen", REQ_out, 1);
  endtask

  function automatic logic [135:0] rand_resp();
    logic [135:0] r;
    r[31:0]    = $urandom;
    r[63:32]   = $urandom;
    r[95:64]   = $urandom;
    r[127:96]  = $urandom;
    r[135:128] = 8'($urandom);
    return r;
  endfunction

  // Act as the PHY for the oldest modelled command and check the outcome.
  task automatic serve_one(input int ack_dly, input int resp_dly, input logic [135:0] resp,
                           input int exp_wait);
    int           n;
    cmd_t         c;
    logic [5:0]   e_idx;
    logic [127:0] e_long;
    logic         e_ierr;
    c = mq.pop_front();
    wait_req(n);
    if (exp_wait >= 0) check("issue_gap", n, exp_wait);
    check("cmd_out", cmd_out, {c.idx, c.arg});
    check("busy", cmd_busy, 1);
    repeat (ack_dly) tick();
    check("req_hold", REQ_out, 1);
    ACK_in = 1'b1;
    tick();
    ACK_in = 1'b0;
    check("req_drop", REQ_out, 0);
    repeat (resp_dly - 1) tick();
    check("no_timeout", timeout_error, 0);
    REQ_in = 1'b1; cmd_response = resp;
    tick();
    check("ack_out_rise", ACK_out, 1);
    REQ_in = 1'b0;
    tick();
    if (c.lng) begin
      e_idx = '0; e_long = resp[127:0]; e_ierr = 1'b0;
    end else begin
      e_idx = resp[37:32]; e_long = '0; e_ierr = (resp[37:32] != c.idx);
    end
    m_resp_arg = resp[31:0];
    check("complete", cmd_complete, 1);
    check("index_error", cmd_index_error, e_ierr);
    check("ack_out_fall", ACK_out, 0);
    check("resp_index", response_index, e_idx);
    check("resp_arg", response_arg, m_resp_arg);
    check("resp_long", response_long, e_long);
    tick();
    check("complete_pulse", {cmd_complete, cmd_index_error}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [135:0] resp;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         lng;
    logic         quiet;
    int           n, j, t, rd;

    #3 reset = 1'b0;
    tick(); tick();
    check("rst_req", {REQ_out, ACK_out}, 0);
    check("rst_cmd_out", cmd_out, 0);
    check("rst_flags", {cmd_busy, queue_full, cmd_complete, cmd_index_error, timeout_error}, 0);
    check("rst_resp", {response_index, response_arg, response_long}, 0);
    reset = 1'b1;
    tick();

    // Directed: single short command, index mismatch, long response.
    timeout_value = 16'd20;
    push_cmd(6'h11, 32'hAAAA_AAAA, 1'b0, 1'b1);
    resp = '0; resp[37:0] = {6'h11, 32'h1234_5678};
    serve_one(1, 3, resp, 1);

    push_cmd(6'h3F, 32'h0BAD_F00D, 1'b0, 1'b1);
    resp = rand_resp(); resp[37:32] = 6'h01;
    serve_one(0, 2, resp, 1);

    push_cmd(6'h02, 32'h0000_0100, 1'b1, 1'b1);
    resp = {8'h5A, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF};
    serve_one(2, 5, resp, 1);

    // Randomized transactions; the first responds exactly on the deadline edge.
    for (int i = 0; i < 16; i++) begin
      t = int'($urandom_range(4, 30));
      timeout_value = TO_W'(t);
      idx = 6'($urandom); arg = $urandom; lng = 1'($urandom);
      rd = (i == 0) ? t : int'($urandom_range(1, t));
      resp = rand_resp();
      if ($urandom_range(0, 3) != 0) resp[37:32] = idx;
      push_cmd(idx, arg, lng, 1'b1);
      serve_one(int'($urandom_range(0, 3)), rd, resp, 1);
    end

    // Zero timeout value means wait indefinitely.
    timeout_value = '0;
    push_cmd(6'h07, $urandom, 1'b0, 1'b1);
    serve_one(0, 45, rand_resp(), 1);

    // Timeout: PHY never responds.
    timeout_value = 16'd15;
    push_cmd(6'h05, 32'hCAFE_0005, 1'b0, 1'b1);
    void'(mq.pop_front());
    for (int k = 0; k < ISSUES; k++) begin
      wait_req(n);
      check("to_cmd_out", cmd_out, {6'h05, 32'hCAFE_0005});
      ACK_in = 1'b1;
      tick();
      ACK_in = 1'b0;
      j = 0;
      while (j < 40) begin
        tick();
        j++;
        if (REQ_out || timeout_error) break;
      end
      check("to_cycles", j, 15);
      check("to_error", timeout_error, (k == ISSUES - 1));
      check("to_reissue", REQ_out, (k != ISSUES - 1));
    end
    tick();
    check("to_pulse", timeout_error, 0);
    check("to_idle", cmd_busy, 0);
    check("to_resp_kept", response_arg, m_resp_arg);

    // Queue fill: one in flight, DEPTH queued, overflow dropped.
    timeout_value = 16'd20;
    push_cmd(6'h20, $urandom, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_cmd(6'(6'h21 + i), $urandom, 1'($urandom), (i < DEPTH));
      check("queue_full", queue_full, (i >= DEPTH - 1));
    end
    serve_one(0, 2, rand_resp(), 0);
    while (mq.size() > 0) serve_one(int'($urandom_range(0, 2)), 3, rand_resp(), 1);
    repeat (5) tick();
    check("fill_drained", {REQ_out, cmd_busy, queue_full}, 0);

    // Abort while waiting for a response with two commands queued.
    push_cmd(6'h30, $urandom, 1'b0, 1'b1);
    push_cmd(6'h31, $urandom, 1'b0, 1'b1);
    push_cmd(6'h32, $urandom, 1'b0, 1'b1);
    wait_req(n);
    ACK_in = 1'b1;
    tick();
    ACK_in = 1'b0;
    repeat (3) tick();
    cmd_error = 1'b1; new_cmd = 1'b1; cmd_index = 6'h33;
    tick();
    cmd_error = 1'b0; new_cmd = 1'b0;
    mq.delete();
    check("abort_hs", {REQ_out, ACK_out}, 0);
    check("abort_idle", {cmd_busy, queue_full}, 0);
    quiet = 1'b0;
    repeat (25) begin
      tick();
      quiet = quiet | cmd_complete | cmd_index_error | timeout_error | REQ_out | cmd_busy;
    end
    check("abort_quiet", quiet, 0);

    // Reset asserted mid-handshake clears outputs without a clock edge.
    push_cmd(6'h15, 32'h1515_1515, 1'b0, 1'b1);
    wait_req(n);
    #2 reset = 1'b0;
    #1;
    check("async_rst", {REQ_out, cmd_busy, cmd_out}, 0);
    mq.delete();
    tick();
    reset = 1'b1;
    tick();
    push_cmd(6'h16, 32'h1616_1616, 1'b0, 1'b1);
    resp = rand_resp(); resp[37:32] = 6'h16;
    serve_one(1, 4, resp, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
